// File: rtl/p_predict_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : p_predict_serial_if
// Purpose  : Bundles the start/Q-capture inputs, the P/F operands and the
//            busy/done/Pp result bus of the serial covariance predictor.
// Revision : 1.0  initial release
// ============================================================================
interface p_predict_serial_if #(
  parameter int N = 32
);
  logic                start;
  logic                q_valid;
  logic signed [N-1:0] Q11, Q12, Q21, Q22;
  logic signed [N-1:0] P11, P12, P21, P22;
  logic signed [N-1:0] F11, F12, F21, F22;
  logic                busy;
  logic                done;
  logic signed [N-1:0] Pp11, Pp12, Pp21, Pp22;

  // Requester side: drives the operands, observes the result.
  modport master (
    output start, q_valid, Q11, Q12, Q21, Q22,
           P11, P12, P21, P22, F11, F12, F21, F22,
    input  busy, done, Pp11, Pp12, Pp21, Pp22
  );

  // Predictor side.
  modport slave (
    input  start, q_valid, Q11, Q12, Q21, Q22,
           P11, P12, P21, P22, F11, F12, F21, F22,
    output busy, done, Pp11, Pp12, Pp21, Pp22
  );
endinterface
`default_nettype wire

// File: rtl/p_predict_serial.sv
`default_nettype none
// ============================================================================
// Module   : p_predict_serial
// Purpose  : 2x2 Kalman covariance predict P_pred = F*P*F^T + Q in signed
//            fixed point, using one shared multiply-accumulate sequenced over
//            16 cycles (8 MACs for A = F*P, 8 for A*F^T + Q).
// Revision : 1.0  initial release
// ============================================================================
module p_predict_serial #(
  parameter int N    = 32,
  parameter int FRAC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  p_predict_serial_if.slave   bus
);

  localparam int W = 2 * N + 2;   // accumulator width

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAITQ = 2'd1,
    S_FP    = 2'd2,
    S_FPF   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic        done_q, done_d;
  logic        accept, take_q;
  logic        q_have_q;

  // Matrices indexed {row, col}: 0=11, 1=12, 2=21, 3=22.
  logic signed [N-1:0] q_in [4];
  logic signed [N-1:0] p_in [4];
  logic signed [N-1:0] f_in [4];
  logic signed [N-1:0] q_hold_q [4];
  logic signed [N-1:0] q_use_q  [4];
  logic signed [N-1:0] p_q   [4];
  logic signed [N-1:0] f_q   [4];
  logic signed [N-1:0] a_q   [4];
  logic signed [N-1:0] pps_q [4];
  logic signed [N-1:0] pp_q  [4];
  logic signed [W-1:0] acc_q;

  assign q_in[0] = bus.Q11;  assign q_in[1] = bus.Q12;
  assign q_in[2] = bus.Q21;  assign q_in[3] = bus.Q22;
  assign p_in[0] = bus.P11;  assign p_in[1] = bus.P12;
  assign p_in[2] = bus.P21;  assign p_in[3] = bus.P22;
  assign f_in[0] = bus.F11;  assign f_in[1] = bus.F12;
  assign f_in[2] = bus.F21;  assign f_in[3] = bus.F22;

  // Step decode: i = output row, j = output column, t = which product term.
  logic       w_i, w_j, w_t;
  logic [1:0] w_idx;
  assign w_i   = k_q[2];
  assign w_j   = k_q[1];
  assign w_t   = k_q[0];
  assign w_idx = {w_i, w_j};

  // Clamp a normalised accumulator value into the signed N-bit range.
  function automatic logic signed [N-1:0] sat(input logic signed [W-1:0] v);
    logic [W-N:0] top;
    top = v[W-1:N-1];
    if ((&top) || !(|top)) sat = v[N-1:0];
    else if (v[W-1])       sat = {1'b1, {(N-1){1'b0}}};
    else                   sat = {1'b0, {(N-1){1'b1}}};
  endfunction

  // State register and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: start is only honoured in IDLE; a held or same-edge Q
  // lets the run skip WAITQ.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    take_q  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (q_have_q || bus.q_valid) begin
            take_q  = 1'b1;
            state_d = S_FP;
            k_d     = 3'd0;
          end else begin
            state_d = S_WAITQ;
          end
        end
      end
      S_WAITQ: begin
        if (bus.q_valid) begin
          take_q  = 1'b1;
          state_d = S_FP;
          k_d     = 3'd0;
        end
      end
      S_FP: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) state_d = S_FPF;
      end
      S_FPF: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Q capture: a newer q_valid overwrites an unconsumed one; consuming wins
  // over a same-edge capture so the flag does not linger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_have_q <= 1'b0;
      for (int n = 0; n < 4; n++) q_hold_q[n] <= '0;
    end else begin
      if (bus.q_valid) begin
        for (int n = 0; n < 4; n++) q_hold_q[n] <= q_in[n];
      end
      if (take_q)            q_have_q <= 1'b0;
      else if (bus.q_valid)  q_have_q <= 1'b1;
    end
  end

  // Operand snapshots for the run: P,F on accept, Q when the run commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        p_q[n]     <= '0;
        f_q[n]     <= '0;
        q_use_q[n] <= '0;
      end
    end else begin
      if (accept) begin
        for (int n = 0; n < 4; n++) begin
          p_q[n] <= p_in[n];
          f_q[n] <= f_in[n];
        end
      end
      if (take_q) begin
        for (int n = 0; n < 4; n++)
          q_use_q[n] <= bus.q_valid ? q_in[n] : q_hold_q[n];
      end
    end
  end

  // Shared multiplier operand select: F_it*P_tj in FP, A_it*F_jt in FPF.
  logic signed [N-1:0] w_op_a, w_op_b;
  always_comb begin
    w_op_a = f_q[{w_i, w_t}];
    w_op_b = p_q[{w_t, w_j}];
    if (state_q == S_FPF) begin
      w_op_a = a_q[{w_i, w_t}];
      w_op_b = f_q[{w_j, w_t}];
    end
  end

  logic signed [2*N-1:0] w_prod;
  logic signed [W-1:0]   w_prod_ext, w_q_sh, w_sum, w_norm;
  logic signed [N-1:0]   w_sat;
  assign w_prod     = (2*N)'(w_op_a) * (2*N)'(w_op_b);
  assign w_prod_ext = W'(w_prod);
  assign w_q_sh     = W'(q_use_q[w_idx]) <<< FRAC;
  assign w_sum      = acc_q + w_prod_ext;
  assign w_norm     = w_sum >>> FRAC;
  assign w_sat      = sat(w_norm);

  // MAC datapath: first term loads acc, second term finishes an element.
  // Pp outputs are staged and all committed together on the done edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      for (int n = 0; n < 4; n++) begin
        a_q[n]   <= '0;
        pps_q[n] <= '0;
        pp_q[n]  <= '0;
      end
    end else if (state_q == S_FP || state_q == S_FPF) begin
      if (!w_t) begin
        acc_q <= (state_q == S_FPF) ? (w_prod_ext + w_q_sh) : w_prod_ext;
      end else if (state_q == S_FP) begin
        a_q[w_idx] <= w_sat;
      end else begin
        pps_q[w_idx] <= w_sat;
        if (k_q == 3'd7) begin
          pp_q[0] <= pps_q[0];
          pp_q[1] <= pps_q[1];
          pp_q[2] <= pps_q[2];
          pp_q[3] <= w_sat;
        end
      end
    end
  end

  assign bus.busy = (state_q != S_IDLE) || done_q;
  assign bus.done = done_q;
  assign bus.Pp11 = pp_q[0];
  assign bus.Pp12 = pp_q[1];
  assign bus.Pp21 = pp_q[2];
  assign bus.Pp22 = pp_q[3];

endmodule
`default_nettype wire

// File: tb/tb_p_predict_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_p_predict_serial
// Purpose  : Directed self-checking bench for p_predict_serial (N=32,
//            FRAC=16) with a queue of expected Pp results.
// Revision : 1.0  initial release
// ============================================================================
module tb_p_predict_serial;

  localparam int N = 32;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  p_predict_serial_if #(.N(N)) bus ();

  p_predict_serial #(.N(N), .FRAC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] p11, p12, p21, p22;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, b, c, d);
    exp_t e;
    e.p11 = a; e.p12 = b; e.p21 = c; e.p22 = d;
    sb.push_back(e);
  endtask

  task automatic pulse_q(input logic [31:0] a, b, c, d);
    bus.q_valid = 1'b1;
    bus.Q11 = a; bus.Q12 = b; bus.Q21 = c; bus.Q22 = d;
    tick();
    bus.q_valid = 1'b0;
  endtask

  task automatic set_pf(input logic [31:0] p11, p12, p21, p22,
                        input logic [31:0] f11, f12, f21, f22);
    bus.P11 = p11; bus.P12 = p12; bus.P21 = p21; bus.P22 = p22;
    bus.F11 = f11; bus.F12 = f12; bus.F21 = f21; bus.F22 = f22;
  endtask

  // Drive start for one edge; returns just after that edge.
  task automatic do_start(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, ".busy_after_start"}, {63'd0, bus.busy}, 64'd1);
  endtask

  // Wait for done, expecting it after 'lat' more edges, then score the result.
  task automatic wait_done(input string tag, input int lat);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, ".done_seen"}, {63'd0, bus.done}, 64'd1);
    if (bus.done) begin
      check({tag, ".latency"}, 64'(cyc), 64'(lat));
      check({tag, ".busy_at_done"}, {63'd0, bus.busy}, 64'd1);
    end
    check({tag, ".sb_nonempty"}, {63'd0, (sb.size() != 0)}, 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (bus.done) begin
        check({tag, ".Pp11"}, {32'd0, bus.Pp11}, {32'd0, e.p11});
        check({tag, ".Pp12"}, {32'd0, bus.Pp12}, {32'd0, e.p12});
        check({tag, ".Pp21"}, {32'd0, bus.Pp21}, {32'd0, e.p21});
        check({tag, ".Pp22"}, {32'd0, bus.Pp22}, {32'd0, e.p22});
      end
    end
  endtask

  initial begin
    int dones;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.q_valid = 1'b0;
    bus.Q11 = '0; bus.Q12 = '0; bus.Q21 = '0; bus.Q22 = '0;
    set_pf(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    tick(); tick();
    check("rst.busy", {63'd0, bus.busy}, 64'd0);
    check("rst.done", {63'd0, bus.done}, 64'd0);
    check("rst.Pp11", {32'd0, bus.Pp11}, 64'd0);
    check("rst.Pp22", {32'd0, bus.Pp22}, 64'd0);
    rst_n = 1'b1;
    tick();

    // T1: F=I, P=diag(1,2), Q=diag(0.5,0.5)
    pulse_q(32'h8000, 0, 0, 32'h8000);
    set_pf(ONE, 0, 0, 32'h2_0000, ONE, 0, 0, ONE);
    push_exp(32'h1_8000, 0, 0, 32'h2_8000);
    do_start("t1");
    wait_done("t1", 16);
    tick();
    check("t1.busy_after_done", {63'd0, bus.busy}, 64'd0);
    check("t1.Pp11_held", {32'd0, bus.Pp11}, 64'h1_8000);

    // T2: F=[[1,1],[0,1]], P=I, Q=0
    pulse_q(0, 0, 0, 0);
    set_pf(ONE, 0, 0, ONE, ONE, ONE, 0, ONE);
    push_exp(32'h2_0000, ONE, ONE, ONE);
    do_start("t2");
    wait_done("t2", 16);

    // T8: asymmetric P and Q, negative element
    // A = [[1,1.5],[0,1]]; Pp = [[4,1.5],[2,1]] + Q12=0.125
    pulse_q(0, 32'h2000, 0, 0);
    set_pf(ONE, 32'hFFFF_8000, 0, ONE, ONE, 32'h2_0000, 0, ONE);
    push_exp(32'h4_0000, 32'h1_A000, 32'h2_0000, ONE);
    do_start("t8");
    wait_done("t8", 16);

    // T3: start with no Q held -> WAITQ until q_valid
    set_pf(0, 0, 0, 0, ONE, 0, 0, ONE);
    push_exp(ONE, 0, 0, ONE);
    do_start("t3");
    repeat (4) tick();
    check("t3.busy_waitq", {63'd0, bus.busy}, 64'd1);
    check("t3.no_done_waitq", {63'd0, bus.done}, 64'd0);
    pulse_q(ONE, 0, 0, ONE);
    wait_done("t3", 16);

    // T4: start and q_valid on the same edge
    tick();
    set_pf(0, 0, 0, 0, ONE, 0, 0, ONE);
    push_exp(32'hC000, 0, 0, 32'hC000);
    bus.q_valid = 1'b1;
    bus.Q11 = 32'hC000; bus.Q12 = 0; bus.Q21 = 0; bus.Q22 = 32'hC000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.q_valid = 1'b0;
    wait_done("t4", 16);

    // T5: mid-run q_valid does not affect the current run; next run uses it
    pulse_q(ONE, 0, 0, ONE);
    set_pf(0, 0, 0, 0, ONE, 0, 0, ONE);
    push_exp(ONE, 0, 0, ONE);
    do_start("t5a");
    repeat (4) tick();
    pulse_q(32'h4000, 0, 0, 32'h4000);
    wait_done("t5a", 11);
    push_exp(32'h4000, 0, 0, 32'h4000);
    do_start("t5b");                 // accepted in the done cycle
    repeat (5) tick();
    check("t5b.Pp11_held_midrun", {32'd0, bus.Pp11}, {32'd0, ONE});
    wait_done("t5b", 11);

    // T6: saturation
    pulse_q(0, 0, 0, 0);
    set_pf(32'h7530_0000, 0, 0, ONE, 32'h2_0000, 0, 0, ONE);
    push_exp(32'h7FFF_FFFF, 0, 0, ONE);
    do_start("t6");
    wait_done("t6", 16);

    // T7: reset mid-FP aborts the run
    pulse_q(ONE, 0, 0, ONE);
    set_pf(ONE, 0, 0, ONE, ONE, 0, 0, ONE);
    do_start("t7");
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("t7.busy", {63'd0, bus.busy}, 64'd0);
    check("t7.done", {63'd0, bus.done}, 64'd0);
    check("t7.Pp11", {32'd0, bus.Pp11}, 64'd0);
    check("t7.Pp22", {32'd0, bus.Pp22}, 64'd0);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.done) dones++;
    end
    check("t7.no_done_after_reset", 64'(dones), 64'd0);
    check("t7.busy_idle", {63'd0, bus.busy}, 64'd0);
    check("end.sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
